// File: rtl/sync_fifo_param_pkg.sv
// Shared definitions for the parametrised synchronous FIFO.
//   FIFO_MODE_STD  : registered read, one cycle of latency after ren
//   FIFO_MODE_FWFT : show-ahead, head word presented on dout while not empty
//   clog2()        : ceiling log2 used to size addresses and pointers
package sync_fifo_param_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Handshake/status bundle between a FIFO user and sync_fifo_param.
//   master : the user side, drives flush/wen/din/ren/clr_err, observes status
//   slave  : the FIFO side, returns dout/valid/flags/count/error bits
interface sync_fifo_param_if
  import sync_fifo_param_pkg::*;
#(
  parameter int DATA_W = 7,
  parameter int DEPTH  = 16
);

  localparam int ADDR_W = clog2(DEPTH);

  logic              flush;
  logic              wen;
  logic [DATA_W-1:0] din;
  logic              ren;
  logic              clr_err;
  logic [DATA_W-1:0] dout;
  logic              valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, wen, din, ren, clr_err,
    input  dout, valid, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  flush, wen, din, ren, clr_err,
    output dout, valid, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_param_ram_dp.sv
// fifo_ram_dp: DEPTH x DATA_W storage for the FIFO.
//   clk    : write clock
//   we     : write enable, w_data stored at w_addr on the rising edge
//   r_addr : read address, r_data follows combinationally (async read)
// Contents are never reset; the FIFO pointers decide what is meaningful.
module fifo_ram_dp #(
  parameter int DATA_W = 7,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[w_addr] <= w_data;
    end
  end

  assign r_data = mem[r_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO between transform stages.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : slave side of sync_fifo_param_if
//                (flush/wen/din/ren/clr_err in; dout/valid/full/empty/
//                 almost_full/almost_empty/count/overflow/underflow out)
// FWFT selects a registered read port or a show-ahead read port.
module sync_fifo_param
  import sync_fifo_param_pkg::*;
#(
  parameter int DATA_W    = 7,
  parameter int DEPTH     = 16,
  parameter int FWFT      = FIFO_MODE_STD,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sync_fifo_param_if.slave     bus
);

  localparam int ADDR_W = clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_THRESH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  logic [ADDR_W:0]   w_ptr_reg, w_ptr_next;
  logic [ADDR_W:0]   r_ptr_reg, r_ptr_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic              overflow_reg, overflow_next;
  logic              underflow_reg, underflow_next;

  logic              empty;
  logic              full;
  logic              rd_ok;
  logic              wr_ok;
  logic              rd_en;
  logic              wr_en;
  logic [DATA_W-1:0] ram_rdata;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == DEPTH_C);

  // A write into a full FIFO is allowed only when a read frees a slot in
  // the same cycle; a read of an empty FIFO is never bypassed from din.
  assign rd_ok = bus.ren & ~empty;
  assign wr_ok = bus.wen & (~full | rd_ok);

  // Flush wins over both requests for the cycle.
  assign rd_en = rd_ok & ~bus.flush;
  assign wr_en = wr_ok & ~bus.flush;

  always_comb begin
    w_ptr_next     = w_ptr_reg;
    r_ptr_next     = r_ptr_reg;
    count_next     = count_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;

    if (bus.flush) begin
      w_ptr_next = '0;
      r_ptr_next = '0;
      count_next = '0;
    end else begin
      if (wr_en) begin
        w_ptr_next = w_ptr_reg + ONE_C;
      end
      if (rd_en) begin
        r_ptr_next = r_ptr_reg + ONE_C;
      end
      case ({wr_en, rd_en})
        2'b10:   count_next = count_reg + ONE_C;
        2'b01:   count_next = count_reg - ONE_C;
        default: count_next = count_reg;
      endcase
    end

    // Sticky errors: a set in the same cycle as clr_err wins. Flush leaves
    // the error state alone, so a flushed request does not raise a flag.
    if (bus.clr_err) begin
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end
    if (~bus.flush & bus.wen & full & ~rd_ok) begin
      overflow_next = 1'b1;
    end
    if (~bus.flush & bus.ren & empty) begin
      underflow_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr_reg     <= '0;
      r_ptr_reg     <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      w_ptr_reg     <= w_ptr_next;
      r_ptr_reg     <= r_ptr_next;
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  fifo_ram_dp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk    (clk),
    .we     (wr_en),
    .w_addr (w_ptr_reg[ADDR_W-1:0]),
    .w_data (bus.din),
    .r_addr (r_ptr_reg[ADDR_W-1:0]),
    .r_data (ram_rdata)
  );

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // Head word is shown directly; an empty FIFO presents zero so that
      // dout has a defined value out of reset despite the unreset array.
      assign bus.dout  = empty ? '0 : ram_rdata;
      assign bus.valid = ~empty;
    end else begin : g_std
      logic [DATA_W-1:0] dout_reg;
      logic              valid_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_reg  <= '0;
          valid_reg <= 1'b0;
        end else begin
          valid_reg <= rd_en;
          if (rd_en) begin
            dout_reg <= ram_rdata;
          end
        end
      end

      assign bus.dout  = dout_reg;
      assign bus.valid = valid_reg;
    end
  endgenerate

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_reg >= AF_C);
  assign bus.almost_empty = (count_reg <= AE_C);
  assign bus.count        = count_reg;
  assign bus.overflow     = overflow_reg;
  assign bus.underflow    = underflow_reg;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param. Two instances (registered read
// and show-ahead) receive identical stimulus. A queue-based model tracks
// the expected contents; directed table rows carry hand-derived results.
module tb_sync_fifo_param;

  localparam int DW    = 7;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 4;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  sync_fifo_param_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus0 ();
  sync_fifo_param_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus1 ();

  sync_fifo_param #(
    .DATA_W(DW), .DEPTH(DEPTH), .FWFT(0), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut_std (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  sync_fifo_param #(
    .DATA_W(DW), .DEPTH(DEPTH), .FWFT(1), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut_fwft (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] mq[$];
  bit            m_ovf;
  bit            m_unf;
  bit            m_valid0;
  logic [DW-1:0] m_dout0;

  typedef struct {
    bit            f;
    bit            w;
    bit            r;
    bit            c;
    logic [DW-1:0] d;
    int            cnt;
    bit            full;
    bit            empty;
    bit            af;
    bit            ae;
    bit            ovf;
    bit            unf;
    bit            vld;
    bit            chk_d;
    logic [DW-1:0] dout;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
    m_valid0 = 1'b0;
    m_dout0  = '0;
  endtask

  task automatic drive(input bit f, input bit w, input bit r, input bit c,
                       input logic [DW-1:0] d);
    bus0.flush = f; bus0.wen = w; bus0.ren = r; bus0.clr_err = c; bus0.din = d;
    bus1.flush = f; bus1.wen = w; bus1.ren = r; bus1.clr_err = c; bus1.din = d;
  endtask

  task automatic compare_model();
    int sz;
    sz = mq.size();
    check("std.count", int'(bus0.count), sz);
    check("std.empty", int'(bus0.empty), int'(sz == 0));
    check("std.full", int'(bus0.full), int'(sz == DEPTH));
    check("std.almost_full", int'(bus0.almost_full), int'(sz >= AF));
    check("std.almost_empty", int'(bus0.almost_empty), int'(sz <= AE));
    check("std.overflow", int'(bus0.overflow), int'(m_ovf));
    check("std.underflow", int'(bus0.underflow), int'(m_unf));
    check("std.valid", int'(bus0.valid), int'(m_valid0));
    check("std.dout", int'(bus0.dout), int'(m_dout0));
    check("fwft.count", int'(bus1.count), sz);
    check("fwft.overflow", int'(bus1.overflow), int'(m_ovf));
    check("fwft.underflow", int'(bus1.underflow), int'(m_unf));
    check("fwft.valid", int'(bus1.valid), int'(sz != 0));
    if (sz != 0) begin
      check("fwft.dout", int'(bus1.dout), int'(mq[0]));
    end
  endtask

  // One clock of stimulus: model update, edge, then compare at edge+1.
  task automatic cycle(input bit f, input bit w, input bit r, input bit c,
                       input logic [DW-1:0] d);
    int sz;
    bit rd;
    bit wr;
    bit set_o;
    bit set_u;
    sz    = mq.size();
    rd    = 1'b0;
    wr    = 1'b0;
    set_o = 1'b0;
    set_u = 1'b0;
    drive(f, w, r, c, d);
    if (f) begin
      mq.delete();
      m_valid0 = 1'b0;
    end else begin
      rd    = r && (sz > 0);
      wr    = w && ((sz < DEPTH) || rd);
      set_o = w && (sz == DEPTH) && !rd;
      set_u = r && (sz == 0);
      if (rd) begin
        m_dout0  = mq.pop_front();
        m_valid0 = 1'b1;
      end else begin
        m_valid0 = 1'b0;
      end
      if (wr) mq.push_back(d);
    end
    m_ovf = set_o || (m_ovf && !c);
    m_unf = set_u || (m_unf && !c);
    @(posedge clk);
    #1;
    $display("txn f=%0d w=%0d r=%0d c=%0d din=%02h : count=%0d dout=%02h valid=%0d fwft_dout=%02h",
             f, w, r, c, d, bus0.count, bus0.dout, bus0.valid, bus1.dout);
    compare_model();
  endtask

  function automatic void add(input bit f, input bit w, input bit r, input bit c,
                              input logic [DW-1:0] d, input int cnt, input bit ovf,
                              input bit unf, input bit vld, input bit chk_d,
                              input logic [DW-1:0] dout);
    vec_t v;
    v.f = f; v.w = w; v.r = r; v.c = c; v.d = d;
    v.cnt   = cnt;
    v.full  = (cnt == DEPTH);
    v.empty = (cnt == 0);
    v.af    = (cnt >= AF);
    v.ae    = (cnt <= AE);
    v.ovf = ovf; v.unf = unf; v.vld = vld; v.chk_d = chk_d; v.dout = dout;
    vt.push_back(v);
  endfunction

  initial begin
    logic [DW-1:0] rnd_d;
    bit            rf;
    bit            rc;
    int            budget;

    // Directed table, derived by hand from the FIFO rules
    for (int i = 1; i <= 16; i++)
      add(0, 1, 0, 0, DW'(i), i, 0, 0, 0, 0, '0);
    add(0, 1, 0, 0, 7'd17, 16, 1, 0, 0, 0, '0);
    for (int k = 0; k < 16; k++)
      add(0, 0, 1, 0, '0, 15 - k, 1, 0, 1, 1, DW'(k + 1));
    add(0, 0, 1, 0, '0, 0, 1, 1, 0, 1, 7'd16);
    add(0, 0, 0, 1, '0, 0, 0, 0, 0, 1, 7'd16);
    for (int i = 1; i <= 16; i++)
      add(0, 1, 0, 0, DW'(i), i, 0, 0, 0, 0, '0);
    add(0, 1, 1, 0, 7'h55, 16, 0, 0, 1, 1, 7'd1);
    for (int k = 0; k < 15; k++)
      add(0, 0, 1, 0, '0, 15 - k, 0, 0, 1, 1, DW'(k + 2));
    add(0, 0, 1, 0, '0, 0, 0, 0, 1, 1, 7'h55);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    compare_model();
    check("reset.dout", int'(bus0.dout), 0);
    check("reset.almost_empty", int'(bus0.almost_empty), 1);

    foreach (vt[i]) begin
      cycle(vt[i].f, vt[i].w, vt[i].r, vt[i].c, vt[i].d);
      check("tbl.count", int'(bus0.count), vt[i].cnt);
      check("tbl.full", int'(bus0.full), int'(vt[i].full));
      check("tbl.empty", int'(bus0.empty), int'(vt[i].empty));
      check("tbl.almost_full", int'(bus0.almost_full), int'(vt[i].af));
      check("tbl.almost_empty", int'(bus0.almost_empty), int'(vt[i].ae));
      check("tbl.overflow", int'(bus0.overflow), int'(vt[i].ovf));
      check("tbl.underflow", int'(bus0.underflow), int'(vt[i].unf));
      check("tbl.valid", int'(bus0.valid), int'(vt[i].vld));
      if (vt[i].chk_d) check("tbl.dout", int'(bus0.dout), int'(vt[i].dout));
    end

    // Wrap: 40 words in bursts of five, pointers pass the end repeatedly
    for (int b = 0; b < 8; b++) begin
      for (int j = 0; j < 5; j++) cycle(0, 1, 0, 0, DW'(b * 5 + j + 1));
      for (int j = 0; j < 5; j++) begin
        cycle(0, 0, 1, 0, '0);
        check("wrap.dout", int'(bus0.dout), b * 5 + j + 1);
      end
    end

    // Show-ahead: word visible the cycle after writing, no ren needed
    cycle(0, 1, 0, 0, 7'h2A);
    check("fwft.show_dout", int'(bus1.dout), 'h2A);
    check("fwft.show_valid", int'(bus1.valid), 1);
    check("fwft.std_valid", int'(bus0.valid), 0);
    cycle(0, 0, 1, 0, '0);
    check("fwft.pop_empty", int'(bus1.empty), 1);
    check("fwft.pop_valid", int'(bus1.valid), 0);

    // Flush after nine words
    for (int i = 0; i < 9; i++) cycle(0, 1, 0, 0, DW'(i + 60));
    cycle(1, 1, 1, 0, 7'h11);
    check("flush.count", int'(bus0.count), 0);
    check("flush.empty", int'(bus0.empty), 1);
    check("flush.overflow", int'(bus0.overflow), 0);

    // Set both error flags, then reset asynchronously mid-burst
    cycle(0, 0, 1, 0, '0);
    for (int i = 0; i < 18; i++) cycle(0, 1, 0, 0, DW'(i));
    cycle(0, 0, 1, 0, '0);
    drive(0, 1, 1, 0, 7'h33);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst.count", int'(bus0.count), 0);
    check("arst.empty", int'(bus0.empty), 1);
    check("arst.full", int'(bus0.full), 0);
    check("arst.almost_full", int'(bus0.almost_full), 0);
    check("arst.overflow", int'(bus0.overflow), 0);
    check("arst.underflow", int'(bus0.underflow), 0);
    check("arst.valid", int'(bus0.valid), 0);
    check("arst.dout", int'(bus0.dout), 0);
    check("arst.fwft_valid", int'(bus1.valid), 0);
    drive(0, 0, 0, 0, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    compare_model();

    // clr_err: same-cycle set wins, plain clear clears
    cycle(0, 0, 1, 1, '0);
    check("clr.set_wins", int'(bus0.underflow), 1);
    cycle(0, 0, 0, 1, '0);
    check("clr.clears", int'(bus0.underflow), 0);

    // Randomised traffic in alternating write-heavy/read-heavy phases
    budget = 1500;
    for (int n = 0; n < budget; n++) begin
      int wp;
      wp    = ((n / 100) % 2 == 0) ? 70 : 30;
      rnd_d = DW'($urandom);
      rf    = ($urandom_range(0, 99) == 0);
      rc    = !rf && ($urandom_range(0, 49) == 0);
      cycle(rf, $urandom_range(0, 99) < wp, $urandom_range(0, 99) < (100 - wp),
            rc, rnd_d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
